// File: rtl/udma_spis_pkg.sv
// Shared definitions for the uDMA SPI slave core.
//   spis_state_e          : transfer FSM state (IDLE / ACTIVE)
//   SPIS_WORD_BITS_*      : the supported transfer word widths
//   SPIS_QPI_LANES        : number of data lines used in quad mode
//   spis_word_bits_legal(): true when a word width is one of the supported ones
package udma_spis_pkg;

  typedef enum logic {
    SPIS_IDLE   = 1'b0,
    SPIS_ACTIVE = 1'b1
  } spis_state_e;

  localparam int SPIS_WORD_BITS_8  = 8;
  localparam int SPIS_WORD_BITS_16 = 16;
  localparam int SPIS_WORD_BITS_32 = 32;
  localparam int SPIS_QPI_LANES    = 4;

  function automatic logic spis_word_bits_legal(input int bits);
    return (bits == SPIS_WORD_BITS_8) || (bits == SPIS_WORD_BITS_16) ||
           (bits == SPIS_WORD_BITS_32);
  endfunction

endpackage

// File: rtl/udma_spis_sync.sv
// Two-flop synchronizer plus edge detector for a bundle of asynchronous pads.
// Ports:
//   clk_i, rst_i : block clock, synchronous active-high reset
//   async_i      : raw pad inputs
//   sync_o       : synchronized levels (reset to RESET_VAL)
//   rise_o       : one-cycle pulse per bit on a synchronized 0->1 transition
//   fall_o       : one-cycle pulse per bit on a synchronized 1->0 transition
// Edges are only reported once the whole pipeline holds real pad samples, so
// the reset values can never be mistaken for an edge. A pad already low at
// reset release (e.g. CSN) therefore produces no falling edge.
module udma_spis_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  // fill_q[k] set once stage k (meta, sync, prev) carries a post-reset sample
  logic [2:0]       fill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
      fill_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign sync_o = sync_q;
  assign rise_o = fill_q[2] ? (sync_q & ~prev_q) : '0;
  assign fall_o = fill_q[2] ? (~sync_q & prev_q) : '0;

endmodule

// File: rtl/udma_spis_core.sv
// uDMA SPI slave core: SPI / quad-SPI slave with word streams on both sides.
// Ports:
//   clk_i, rst_i                 : single block clock, sync active-high reset
//   cfg_cpol_i/cpha_i/qpi_i/qpi_tx_i : mode config, captured while IDLE only
//   spi_sck_i, spi_csn_i, spi_sdi0_i..3_i : asynchronous pad inputs
//   spi_sdo0_o..3_o, spi_oe_o    : pad data and per-line output enables
//   rx_data_o/rx_valid_o/rx_ready_i : received words (valid/ready)
//   tx_data_i/tx_valid_i/tx_ready_o : words to transmit (valid/ready)
//   eot_o, rx_ovf_o, tx_udf_o    : one-cycle event pulses
// Handshakes: a word moves on a cycle where valid and ready are both high.
// rx_valid_o stays high until accepted. tx_ready_o is high for one cycle per
// fetch, and only while tx_valid_i is high; a fetch that finds tx_valid_i low
// sends zeros and raises tx_udf_o instead.
module udma_spis_core
  import udma_spis_pkg::*;
#(
  parameter int WORD_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_cpol_i,
  input  logic                 cfg_cpha_i,
  input  logic                 cfg_qpi_i,
  input  logic                 cfg_qpi_tx_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_csn_i,
  input  logic                 spi_sdi0_i,
  input  logic                 spi_sdi1_i,
  input  logic                 spi_sdi2_i,
  input  logic                 spi_sdi3_i,
  output logic                 spi_sdo0_o,
  output logic                 spi_sdo1_o,
  output logic                 spi_sdo2_o,
  output logic                 spi_sdo3_o,
  output logic [3:0]           spi_oe_o,
  output logic [WORD_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic [WORD_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 eot_o,
  output logic                 rx_ovf_o,
  output logic                 tx_udf_o
);

  localparam int CNT_W = $clog2(WORD_BITS);

  if (!spis_word_bits_legal(WORD_BITS)) begin : g_bad_word_bits
    $error("udma_spis_core: WORD_BITS must be 8, 16 or 32");
  end

  // ---------------------------------------------------------------------------
  // Pad synchronization: bit 1 = csn, bit 0 = sck
  // ---------------------------------------------------------------------------
  logic [1:0] pin_sync, pin_rise, pin_fall;
  logic [3:0] sdi_sync, sdi_rise, sdi_fall;

  udma_spis_sync #(.WIDTH(2), .RESET_VAL(2'b10)) u_sync_pins (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i ({spi_csn_i, spi_sck_i}),
    .sync_o  (pin_sync),
    .rise_o  (pin_rise),
    .fall_o  (pin_fall)
  );

  udma_spis_sync #(.WIDTH(4), .RESET_VAL(4'b0000)) u_sync_sdi (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i ({spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}),
    .sync_o  (sdi_sync),
    .rise_o  (sdi_rise),
    .fall_o  (sdi_fall)
  );

  // Only edges of csn/sck and levels of sdi are needed.
  logic unused_sync_sigs;
  assign unused_sync_sigs = ^{pin_sync, sdi_rise, sdi_fall};

  logic csn_rise, csn_fall, sck_rise, sck_fall;
  assign csn_rise = pin_rise[1];
  assign csn_fall = pin_fall[1];
  assign sck_rise = pin_rise[0];
  assign sck_fall = pin_fall[0];

  // ---------------------------------------------------------------------------
  // State and configuration
  // ---------------------------------------------------------------------------
  spis_state_e          state;
  logic                 cpol_q, cpha_q, qpi_q, qpi_tx_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] rx_shift;
  logic [WORD_BITS-1:0] tx_shift;
  logic                 fetch_req;     // one-cycle tx fetch slot
  logic                 fetch_bnd;     // pending fetch is a word boundary
  logic                 skip_launch;   // next launch edge presents bit 0 as-is

  logic                 lead_edge, trail_edge, sample_edge, launch_edge;
  logic [CNT_W-1:0]     last_cnt;
  logic [WORD_BITS-1:0] rx_next;

  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign launch_edge = cpha_q ? lead_edge  : trail_edge;
  assign last_cnt    = qpi_q ? CNT_W'(WORD_BITS / SPIS_QPI_LANES - 1)
                             : CNT_W'(WORD_BITS - 1);
  assign rx_next     = qpi_q ? {rx_shift[WORD_BITS-5:0], sdi_sync}
                             : {rx_shift[WORD_BITS-2:0], sdi_sync[0]};

  assign tx_ready_o  = fetch_req & tx_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= SPIS_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      qpi_q       <= 1'b0;
      qpi_tx_q    <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      fetch_req   <= 1'b0;
      fetch_bnd   <= 1'b0;
      skip_launch <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      eot_o       <= 1'b0;
      rx_ovf_o    <= 1'b0;
      tx_udf_o    <= 1'b0;
    end else begin
      eot_o     <= 1'b0;
      rx_ovf_o  <= 1'b0;
      tx_udf_o  <= 1'b0;
      fetch_req <= 1'b0;

      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      // Load the next tx word in the fetch slot. With cpha=1 the first launch
      // edge of every word is the one that shows bit 0; with cpha=0 bit 0 is
      // already on the pad at entry, but after a word boundary the trailing
      // launch edge that follows must not shift the fresh word.
      if (fetch_req) begin
        tx_shift    <= tx_valid_i ? tx_data_i : '0;
        tx_udf_o    <= ~tx_valid_i;
        skip_launch <= cpha_q | fetch_bnd;
      end

      case (state)
        SPIS_IDLE: begin
          cpol_q   <= cfg_cpol_i;
          cpha_q   <= cfg_cpha_i;
          qpi_q    <= cfg_qpi_i;
          qpi_tx_q <= cfg_qpi_tx_i;
          if (csn_fall) begin
            state     <= SPIS_ACTIVE;
            fetch_req <= 1'b1;
            fetch_bnd <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
          end
        end

        SPIS_ACTIVE: begin
          // CSN rising wins over any sck edge seen on the same cycle.
          if (csn_rise) begin
            state       <= SPIS_IDLE;
            eot_o       <= 1'b1;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            skip_launch <= 1'b0;
          end else begin
            if (sample_edge) begin
              if (bit_cnt == last_cnt) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                fetch_req <= 1'b1;
                fetch_bnd <= 1'b1;
                // A word completing on the accepting cycle still fits.
                if (!rx_valid_o || rx_ready_i) begin
                  rx_data_o  <= rx_next;
                  rx_valid_o <= 1'b1;
                end else begin
                  rx_ovf_o <= 1'b1;
                end
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                rx_shift <= rx_next;
              end
            end
            if (launch_edge) begin
              if (skip_launch) begin
                skip_launch <= 1'b0;
              end else if (qpi_q) begin
                tx_shift <= {tx_shift[WORD_BITS-5:0], 4'b0000};
              end else begin
                tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
              end
            end
          end
        end

        default: state <= SPIS_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pad drive: straight from registers so a launch edge reaches the pads on the
  // same clock that shifts tx_shift.
  // ---------------------------------------------------------------------------
  logic [3:0] sdo;

  always_comb begin
    sdo      = 4'b0000;
    spi_oe_o = 4'b0000;
    if (state == SPIS_ACTIVE) begin
      if (!qpi_q) begin
        spi_oe_o = 4'b0010;
        sdo[1]   = tx_shift[WORD_BITS-1];
      end else if (qpi_tx_q) begin
        spi_oe_o = 4'b1111;
        sdo      = tx_shift[WORD_BITS-1 -: 4];
      end
    end
  end

  assign spi_sdo0_o = sdo[0];
  assign spi_sdo1_o = sdo[1];
  assign spi_sdo2_o = sdo[2];
  assign spi_sdo3_o = sdo[3];

endmodule

// File: tb/tb_udma_spis_core.sv
`timescale 1ns/1ps
module tb_udma_spis_core;

  localparam int W    = 32;
  localparam int HALF = 8;   // clk cycles per sck half period

  logic         clk;
  logic         rst_i;
  logic         cfg_cpol_i, cfg_cpha_i, cfg_qpi_i, cfg_qpi_tx_i;
  logic         spi_sck_i, spi_csn_i;
  logic         spi_sdi0_i, spi_sdi1_i, spi_sdi2_i, spi_sdi3_i;
  logic         spi_sdo0_o, spi_sdo1_o, spi_sdo2_o, spi_sdo3_o;
  logic [3:0]   spi_oe_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o, rx_ready_i;
  logic [W-1:0] tx_data_i;
  logic         tx_valid_i, tx_ready_o;
  logic         eot_o, rx_ovf_o, tx_udf_o;

  int vectors     = 0;
  int miscompares = 0;

  udma_spis_core #(.WORD_BITS(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_cpol_i  (cfg_cpol_i),
    .cfg_cpha_i  (cfg_cpha_i),
    .cfg_qpi_i   (cfg_qpi_i),
    .cfg_qpi_tx_i(cfg_qpi_tx_i),
    .spi_sck_i   (spi_sck_i),
    .spi_csn_i   (spi_csn_i),
    .spi_sdi0_i  (spi_sdi0_i),
    .spi_sdi1_i  (spi_sdi1_i),
    .spi_sdi2_i  (spi_sdi2_i),
    .spi_sdi3_i  (spi_sdi3_i),
    .spi_sdo0_o  (spi_sdo0_o),
    .spi_sdo1_o  (spi_sdo1_o),
    .spi_sdo2_o  (spi_sdo2_o),
    .spi_sdo3_o  (spi_sdo3_o),
    .spi_oe_o    (spi_oe_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .eot_o       (eot_o),
    .rx_ovf_o    (rx_ovf_o),
    .tx_udf_o    (tx_udf_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- event monitor (cumulative counts) ----------------
  int           rx_hs_cnt = 0;
  logic [W-1:0] last_rx   = '0;
  int           eot_cnt   = 0;
  int           ovf_cnt   = 0;
  int           udf_cnt   = 0;
  int           txr_cnt   = 0;
  int           oe_nz_cnt = 0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (rx_valid_o && rx_ready_i) begin
        rx_hs_cnt++;
        last_rx = rx_data_o;
      end
      if (eot_o)            eot_cnt++;
      if (rx_ovf_o)         ovf_cnt++;
      if (tx_udf_o)         udf_cnt++;
      if (tx_ready_o)       txr_cnt++;
      if (spi_oe_o != 4'b0) oe_nz_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SPI master driver ----------------
  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic put_mosi(input logic [63:0] mosi, input int i);
    if (cfg_qpi_i) begin
      {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i} = mosi[63-4*i -: 4];
    end else begin
      {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i} = 3'b000;
      spi_sdi0_i = mosi[63-i];
    end
  endtask

  function automatic logic [63:0] shift_in(input logic [63:0] acc);
    if (cfg_qpi_i) return {acc[59:0], spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o};
    return {acc[62:0], spi_sdo1_o};
  endfunction

  task automatic set_cfg(input logic cpol, input logic cpha, input logic qpi, input logic qtx);
    @(negedge clk);
    cfg_cpol_i = cpol; cfg_cpha_i = cpha; cfg_qpi_i = qpi; cfg_qpi_tx_i = qtx;
  endtask

  task automatic master_start();
    @(negedge clk);
    spi_sck_i = cfg_cpol_i;
    repeat (2*HALF) @(negedge clk);
    spi_csn_i = 1'b0;
    repeat (4*HALF) @(negedge clk);
  endtask

  // n = number of sample edges; mosi is left-aligned, first bit at [63]
  task automatic master_bits(input int n, input logic [63:0] mosi, output logic [63:0] miso);
    miso = '0;
    if (!cfg_cpha_i) begin
      put_mosi(mosi, 0);
      for (int i = 0; i < n; i++) begin
        half_wait();
        miso = shift_in(miso);
        spi_sck_i = ~cfg_cpol_i;
        half_wait();
        spi_sck_i = cfg_cpol_i;
        if (i + 1 < n) put_mosi(mosi, i + 1);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        half_wait();
        spi_sck_i = ~cfg_cpol_i;
        put_mosi(mosi, i);
        half_wait();
        miso = shift_in(miso);
        spi_sck_i = cfg_cpol_i;
      end
    end
  endtask

  task automatic master_end();
    half_wait();
    spi_csn_i = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rx_data_o !== '0) begin miscompares++; $display("FAIL reset rx_data: got %h want 0", rx_data_o); end
    vectors++; if ({rx_valid_o, tx_ready_o, eot_o, rx_ovf_o, tx_udf_o} !== 5'b0) begin miscompares++;
      $display("FAIL reset flags: got %b want 00000", {rx_valid_o, tx_ready_o, eot_o, rx_ovf_o, tx_udf_o}); end
    vectors++; if ({spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o, spi_oe_o} !== 8'h00) begin miscompares++;
      $display("FAIL reset pads: got %h want 00", {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o, spi_oe_o}); end
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_spi_mode(input int mode);
    logic [63:0] miso;
    int rx0, eot0, txr0, udf0, ovf0;
    string tag;
    tag = $sformatf("mode%0d", mode);
    rx0 = rx_hs_cnt; eot0 = eot_cnt; txr0 = txr_cnt; udf0 = udf_cnt; ovf0 = ovf_cnt;
    rx_ready_i = 1'b1; tx_valid_i = 1'b1; tx_data_i = 32'h1234_5678;
    set_cfg(mode[1], mode[0], 1'b0, 1'b0);
    master_start();
    master_bits(32, {32'hA5A5_0F0F, 32'h0}, miso);
    master_end();
    vectors++; if (rx_hs_cnt - rx0 !== 1) begin miscompares++; $display("FAIL %s rx_count: got %0d want 1", tag, rx_hs_cnt - rx0); end
    vectors++; if (last_rx !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL %s rx_data: got %h want a5a50f0f", tag, last_rx); end
    vectors++; if (miso[31:0] !== 32'h1234_5678) begin miscompares++; $display("FAIL %s miso: got %h want 12345678", tag, miso[31:0]); end
    vectors++; if (eot_cnt - eot0 !== 1) begin miscompares++; $display("FAIL %s eot: got %0d want 1", tag, eot_cnt - eot0); end
    vectors++; if (txr_cnt - txr0 !== 2) begin miscompares++; $display("FAIL %s tx_ready: got %0d want 2", tag, txr_cnt - txr0); end
    vectors++; if ((udf_cnt - udf0) + (ovf_cnt - ovf0) !== 0) begin miscompares++;
      $display("FAIL %s udf_ovf: got %0d want 0", tag, (udf_cnt - udf0) + (ovf_cnt - ovf0)); end
  endtask

  task automatic test_qpi_rx();
    logic [63:0] miso;
    int rx0, oe0, eot0;
    rx0 = rx_hs_cnt; oe0 = oe_nz_cnt; eot0 = eot_cnt;
    set_cfg(1'b0, 1'b0, 1'b1, 1'b0);
    master_start();
    master_bits(8, {32'hDEAD_BEEF, 32'h0}, miso);
    master_end();
    vectors++; if (rx_hs_cnt - rx0 !== 1) begin miscompares++; $display("FAIL qpi_rx rx_count: got %0d want 1", rx_hs_cnt - rx0); end
    vectors++; if (last_rx !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL qpi_rx rx_data: got %h want deadbeef", last_rx); end
    vectors++; if (oe_nz_cnt - oe0 !== 0) begin miscompares++; $display("FAIL qpi_rx oe_cycles: got %0d want 0", oe_nz_cnt - oe0); end
    vectors++; if (eot_cnt - eot0 !== 1) begin miscompares++; $display("FAIL qpi_rx eot: got %0d want 1", eot_cnt - eot0); end
  endtask

  task automatic test_qpi_tx();
    logic [63:0] miso;
    tx_data_i = 32'h1234_5678;
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1);
    master_start();
    vectors++; if (spi_oe_o !== 4'b1111) begin miscompares++; $display("FAIL qpi_tx oe: got %b want 1111", spi_oe_o); end
    master_bits(8, {32'h0BAD_F00D, 32'h0}, miso);
    master_end();
    vectors++; if (miso[31:0] !== 32'h1234_5678) begin miscompares++; $display("FAIL qpi_tx miso: got %h want 12345678", miso[31:0]); end
    vectors++; if (last_rx !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL qpi_tx rx_data: got %h want 0badf00d", last_rx); end
  endtask

  task automatic test_rx_overflow();
    logic [63:0] miso;
    int rx0, ovf0;
    rx0 = rx_hs_cnt; ovf0 = ovf_cnt;
    rx_ready_i = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    master_start();
    master_bits(64, {32'hC3C3_1111, 32'h5A5A_F0F0}, miso);
    master_end();
    vectors++; if (rx_valid_o !== 1'b1) begin miscompares++; $display("FAIL ovf held_valid: got %b want 1", rx_valid_o); end
    vectors++; if (rx_data_o !== 32'hC3C3_1111) begin miscompares++; $display("FAIL ovf held_data: got %h want c3c31111", rx_data_o); end
    vectors++; if (ovf_cnt - ovf0 !== 1) begin miscompares++; $display("FAIL ovf pulses: got %0d want 1", ovf_cnt - ovf0); end
    @(negedge clk); rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rx_hs_cnt - rx0 !== 1) begin miscompares++; $display("FAIL ovf rx_count: got %0d want 1", rx_hs_cnt - rx0); end
    vectors++; if (last_rx !== 32'hC3C3_1111) begin miscompares++; $display("FAIL ovf accepted: got %h want c3c31111", last_rx); end
    vectors++; if (rx_valid_o !== 1'b0) begin miscompares++; $display("FAIL ovf valid_after: got %b want 0", rx_valid_o); end
  endtask

  task automatic test_tx_underflow();
    logic [63:0] miso;
    int udf0, txr0;
    udf0 = udf_cnt; txr0 = txr_cnt;
    tx_valid_i = 1'b0; tx_data_i = 32'h1234_5678;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    master_start();
    tx_valid_i = 1'b1;   // the later boundary fetch does find a word
    master_bits(32, {32'h0F0F_A5A5, 32'h0}, miso);
    master_end();
    vectors++; if (miso[31:0] !== 32'h0000_0000) begin miscompares++; $display("FAIL udf miso: got %h want 00000000", miso[31:0]); end
    vectors++; if (udf_cnt - udf0 !== 1) begin miscompares++; $display("FAIL udf pulses: got %0d want 1", udf_cnt - udf0); end
    vectors++; if (txr_cnt - txr0 !== 1) begin miscompares++; $display("FAIL udf tx_ready: got %0d want 1", txr_cnt - txr0); end
    vectors++; if (last_rx !== 32'h0F0F_A5A5) begin miscompares++; $display("FAIL udf rx_data: got %h want 0f0fa5a5", last_rx); end
  endtask

  task automatic full_word_check(input string tag, input logic [31:0] word);
    logic [63:0] miso;
    int rx0;
    rx0 = rx_hs_cnt;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    master_start();
    master_bits(32, {word, 32'h0}, miso);
    master_end();
    vectors++; if (rx_hs_cnt - rx0 !== 1) begin miscompares++; $display("FAIL %s rx_count: got %0d want 1", tag, rx_hs_cnt - rx0); end
    vectors++; if (last_rx !== word) begin miscompares++; $display("FAIL %s rx_data: got %h want %h", tag, last_rx, word); end
    vectors++; if (miso[31:0] !== tx_data_i) begin miscompares++; $display("FAIL %s miso: got %h want %h", tag, miso[31:0], tx_data_i); end
  endtask

  task automatic test_abort_csn();
    logic [63:0] miso;
    int rx0, eot0;
    rx0 = rx_hs_cnt; eot0 = eot_cnt;
    tx_valid_i = 1'b1; tx_data_i = 32'h8765_4321;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    master_start();
    master_bits(13, {32'hFFFF_FFFF, 32'h0}, miso);
    master_end();
    vectors++; if (rx_hs_cnt - rx0 !== 0) begin miscompares++; $display("FAIL abort rx_count: got %0d want 0", rx_hs_cnt - rx0); end
    vectors++; if (rx_valid_o !== 1'b0) begin miscompares++; $display("FAIL abort rx_valid: got %b want 0", rx_valid_o); end
    vectors++; if (eot_cnt - eot0 !== 1) begin miscompares++; $display("FAIL abort eot: got %0d want 1", eot_cnt - eot0); end
    full_word_check("abort_next", 32'h3C96_E11D);
  endtask

  task automatic test_reset_mid();
    logic [63:0] miso;
    int rx0, eot0;
    rx0 = rx_hs_cnt; eot0 = eot_cnt;
    tx_data_i = 32'hCAFE_0123;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    master_start();
    master_bits(20, {32'hFFFF_FFFF, 32'h0}, miso);
    @(negedge clk); rst_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rx_data_o !== '0) begin miscompares++; $display("FAIL rstmid rx_data: got %h want 0", rx_data_o); end
    vectors++; if ({rx_valid_o, tx_ready_o, eot_o, rx_ovf_o, tx_udf_o} !== 5'b0) begin miscompares++;
      $display("FAIL rstmid flags: got %b want 00000", {rx_valid_o, tx_ready_o, eot_o, rx_ovf_o, tx_udf_o}); end
    vectors++; if ({spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o, spi_oe_o} !== 8'h00) begin miscompares++;
      $display("FAIL rstmid pads: got %h want 00", {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o, spi_oe_o}); end
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    // CSN still low: must stay IDLE, so the SPI output enable stays off
    vectors++; if (spi_oe_o !== 4'b0000) begin miscompares++; $display("FAIL rstmid idle_oe: got %b want 0000", spi_oe_o); end
    master_end();
    vectors++; if (eot_cnt - eot0 !== 0) begin miscompares++; $display("FAIL rstmid eot: got %0d want 0", eot_cnt - eot0); end
    vectors++; if (rx_hs_cnt - rx0 !== 0) begin miscompares++; $display("FAIL rstmid rx_count: got %0d want 0", rx_hs_cnt - rx0); end
    full_word_check("rstmid_next", 32'h1357_9BDF);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_i = 1'b1;
    cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_qpi_i = 1'b0; cfg_qpi_tx_i = 1'b0;
    spi_sck_i = 1'b0; spi_csn_i = 1'b1;
    spi_sdi0_i = 1'b0; spi_sdi1_i = 1'b0; spi_sdi2_i = 1'b0; spi_sdi3_i = 1'b0;
    rx_ready_i = 1'b1; tx_data_i = '0; tx_valid_i = 1'b0;

    test_reset();
    for (int m = 0; m < 4; m++) test_spi_mode(m);
    test_qpi_rx();
    test_qpi_tx();
    test_rx_overflow();
    test_tx_underflow();
    test_abort_csn();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
